uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing with a 2-flop input synchronizer.
// data_out updates only on a good stop bit; a bad stop bit raises frame_err instead.
module uart_rx #(
    parameter int N           = 8,
    parameter int COUNT_TICKS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    input  logic         tick,
    output logic [N-1:0] data_out,
    output logic         rx_done,
    output logic         frame_err
);

    localparam int BW = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(COUNT_TICKS - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(COUNT_TICKS / 2 - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(N - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [NW-1:0]  bit_q, bit_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [N-1:0]   data_q, data_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           rx_meta_q, rx_s_q;
    logic           stop_sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (baud_q == BAUD_HALF) begin
                        // Mid start bit: a line back high here was only a glitch.
                        state_d = rx_s_q ? IDLE : DATA;
                        baud_d  = '0;
                        bit_d   = '0;
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (baud_q == BAUD_LAST) begin
                        baud_d  = '0;
                        shift_d = {rx_s_q, shift_q[N-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (baud_q == BAUD_LAST) begin
                        state_d = IDLE;
                    end else begin
                        baud_d = baud_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stop_sample = (state_q == STOP) && tick && (baud_q == BAUD_LAST);
        done_d      = stop_sample && rx_s_q;
        err_d       = stop_sample && !rx_s_q;
        data_d      = done_d ? shift_q : data_q;
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = err_q;

endmodule
